instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Instruction-issue front end for the 4-bit Control core. It holds a small loadable program memory and streams its 4-bit words onto the core's instr input, one per clock, with a stall input. It stops at a halt opcode or at the end of memory, then captures the core's portout as the program result. It replaces hand-driven instruction stimulus, so programs run autonomously on silicon and in simulation.

Parameters:
AW, 4, program memory address width; depth = 2**AW words
IW, 4, instruction word width; matches Control instr
HALT_OP, 4'b1111, opcode that ends the program; never issued to the core
NOP_OP, 4'b0000, value driven on instr when nothing is issued

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
load_en  input  1  program write strobe
load_addr  input  AW  program write address
load_data  input  IW  program write data
start  input  1  begin execution from address 0
stall  input  1  hold issue this cycle
portout  input  4  Control core output port, sampled at program end
instr  output  IW  instruction to Control core
instr_valid  output  1  instr holds a newly issued word this cycle
pc  output  AW  address of the next word to fetch
busy  output  1  high in RUN and DRAIN
done  output  1  program finished; result is valid
result  output  4  portout captured at completion

Behaviour:
- Reset (async, immediate, including mid-run): state=IDLE, pc=0, instr=NOP_OP, instr_valid=0, busy=0, done=0, result=0. Memory contents are not reset and are retained.
- States: IDLE, RUN, DRAIN, DONE. All registers are updated on the rising edge of clk.
- IDLE/DONE:
  - load_en=1 writes mem[load_addr]=load_data.
  - start=1 sets pc=0, done=0 and moves to RUN. start has priority: a load on the same edge is dropped.
  - done holds at 1 throughout DONE.
- RUN, stall=0, mem[pc]!=HALT_OP: instr<=mem[pc], instr_valid<=1, pc<=pc+1.
- RUN, stall=0, mem[pc]==HALT_OP: instr<=NOP_OP, instr_valid<=0, pc holds, go to DRAIN.
- RUN, stall=1: instr holds its value, instr_valid<=0, pc holds. Halt detection is deferred, so stall wins over halt.
- End of memory: issuing address 2**AW-1 (non-halt) goes to DRAIN. pc saturates at 2**AW-1 and does not wrap.
- DRAIN: lasts exactly one cycle so the core can execute its last instruction. instr=NOP_OP, instr_valid=0. On exit: result<=portout, done<=1, go to DONE.
- Ignored inputs: load_en and start are ignored in RUN and DRAIN.
- Latency: start sampled at edge E0 → first instr_valid after E1. With N words before the halt and no stalls, done rises after edge E(N+2).
- busy=1 exactly in RUN and DRAIN. done and busy are never both high.

Test Plan:
- Basic run: load 1001,0110,0100,0101,0111,1111 at addresses 0-5, hold portout=4'b0011, pulse start. Required: instr_valid high on 5 consecutive cycles carrying exactly 1001,0110,0100,0101,0111; 1111 never appears with valid; done=1 two edges after the last issue; result=0011; pc=5.
- Stall: same program with stall=1 for 2 cycles after the second issue. Required: instr holds 0110 with valid=0 for 2 cycles, pc holds at 2, then issue resumes with 0100; no word is lost or duplicated.
- Halt at address 0: start. Required: no instr_valid pulse; done after E2; result=portout.
- Full memory, no halt: all 16 words = 0001, start. Required: 16 consecutive valid issues, pc saturates at 15, DONE reached, done=1.
- Ignored load: load_en during RUN with addr=1, data=1111. Required: the run is unaffected; after done, a restart issues the original mem[1].
- Mid-run reset: assert rst during the 3rd issue. Required: all outputs return to reset values immediately; a subsequent start replays the same program from address 0.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer and its host/core side:
// program load port, run control, issue stream and result.
interface instr_sequencer_if #(
    parameter int AW = 4,
    parameter int IW = 4
);
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic          start;
    logic          stall;
    logic [3:0]    portout;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [3:0]    result;

    modport master (
        output load_en, load_addr, load_data, start, stall, portout,
        input  instr, instr_valid, pc, busy, done, result
    );

    modport slave (
        input  load_en, load_addr, load_data, start, stall, portout,
        output instr, instr_valid, pc, busy, done, result
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction-issue front end: streams a loadable program into the
// Control core, stops at halt or end of memory, then captures portout.
module instr_sequencer #(
    parameter int            AW      = 4,
    parameter int            IW      = 4,
    parameter logic [IW-1:0] HALT_OP = 4'b1111,
    parameter logic [IW-1:0] NOP_OP  = 4'b0000
) (
    input logic               clk,
    input logic               rst,
    instr_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [IW-1:0] mem [2**AW];
    logic [AW-1:0] pc, pc_nx;
    logic [IW-1:0] instr, instr_nx;
    logic          valid, valid_nx;
    logic [3:0]    result, result_nx;
    logic [IW-1:0] word;
    logic          at_end;
    logic          idle_like;

    assign word      = mem[pc];
    assign at_end    = (pc == {AW{1'b1}});
    assign idle_like = (state == IDLE) || (state == DONE);

    // Memory is deliberately outside the reset domain so programs survive rst.
    always_ff @(posedge clk) begin
        if (!rst && idle_like && bus.load_en && !bus.start)
            mem[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= '0;
            instr  <= NOP_OP;
            valid  <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            instr  <= instr_nx;
            valid  <= valid_nx;
            result <= result_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        instr_nx  = instr;
        valid_nx  = 1'b0;
        result_nx = result;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    pc_nx    = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                // Stall is checked first so a pending halt waits for it.
                if (!bus.stall) begin
                    if (word == HALT_OP) begin
                        instr_nx = NOP_OP;
                        state_nx = DRAIN;
                    end else begin
                        instr_nx = word;
                        valid_nx = 1'b1;
                        if (at_end)
                            state_nx = DRAIN;
                        else
                            pc_nx = pc + AW'(1);
                    end
                end
            end
            DRAIN: begin
                instr_nx  = NOP_OP;
                result_nx = bus.portout;
                state_nx  = DONE;
            end
        endcase
    end

    assign bus.instr       = instr;
    assign bus.instr_valid = valid;
    assign bus.pc          = pc;
    assign bus.busy        = (state == RUN) || (state == DRAIN);
    assign bus.done        = (state == DONE);
    assign bus.result      = result;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer: basic run, stall,
// halt at 0, full memory, ignored load and mid-run reset.
module tb_instr_sequencer;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [3:0] issued [0:31];
    int         n_issued;
    int         first_cyc;
    int         last_cyc;
    int         done_cyc;
    int         both_hi;
    int         halt_seen;

    logic [3:0] prog [0:5];

    instr_sequencer_if #(.AW(4), .IW(4)) bus ();

    instr_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_word(input logic [3:0] addr, input logic [3:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        @(posedge clk);
        #1;
        bus.load_en = 1'b0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 6; i++)
            load_word(4'(i), prog[i]);
    endtask

    // Pulses start, then samples every cycle until done or budget expires.
    // When inject is set, a load to address 1 is driven mid-run.
    task automatic run_start(input int budget, input bit inject);
        int cyc;
        n_issued  = 0;
        first_cyc = -1;
        last_cyc  = -1;
        done_cyc  = -1;
        both_hi   = 0;
        halt_seen = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (inject && cyc == 1) begin
                bus.load_en   = 1'b1;
                bus.load_addr = 4'd1;
                bus.load_data = 4'b1111;
            end
            if (inject && cyc == 3)
                bus.load_en = 1'b0;
            if (bus.done && bus.busy)
                both_hi++;
            if (bus.instr_valid) begin
                if (bus.instr == 4'b1111)
                    halt_seen++;
                if (n_issued < 32)
                    issued[n_issued] = bus.instr;
                n_issued++;
                if (first_cyc < 0)
                    first_cyc = cyc;
                last_cyc = cyc;
            end
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
        end
        bus.load_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.instr, bus.instr_valid, bus.pc, bus.busy, bus.done, bus.result}
            !== {4'b0000, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0}) begin
            fails++;
            $display("FAIL reset_outputs: instr=%b valid=%b pc=%0d busy=%b done=%b result=%b",
                     bus.instr, bus.instr_valid, bus.pc, bus.busy, bus.done, bus.result);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        load_basic();
        bus.portout = 4'b0011;
        run_start(30, 1'b0);
        tests++;
        if (n_issued !== 5) begin
            fails++;
            $display("FAIL basic_count: got %0d issues, expected 5", n_issued);
        end
        for (int i = 0; i < 5 && i < n_issued; i++) begin
            tests++;
            if (issued[i] !== prog[i]) begin
                fails++;
                $display("FAIL basic_word%0d: got %b expected %b", i, issued[i], prog[i]);
            end
        end
        tests++;
        if (first_cyc !== 1 || last_cyc !== 5) begin
            fails++;
            $display("FAIL basic_timing: first=%0d last=%0d expected 1 5", first_cyc, last_cyc);
        end
        tests++;
        if (done_cyc !== 7) begin
            fails++;
            $display("FAIL basic_done_cycle: got %0d expected 7", done_cyc);
        end
        tests++;
        if (bus.result !== 4'b0011 || bus.pc !== 4'd5) begin
            fails++;
            $display("FAIL basic_result_pc: result=%b pc=%0d expected 0011 5", bus.result, bus.pc);
        end
        tests++;
        if (halt_seen !== 0 || both_hi !== 0) begin
            fails++;
            $display("FAIL basic_flags: halt_seen=%0d both_hi=%0d expected 0 0", halt_seen, both_hi);
        end
        tests++;
        if (bus.instr !== 4'b0000 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle_out: instr=%b busy=%b expected 0000 0", bus.instr, bus.busy);
        end
    endtask

    task automatic test_stall();
        int cyc;
        int n;
        logic [3:0] got [0:15];
        bus.portout = 4'b0101;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL stall_start: done=%b busy=%b expected 0 1", bus.done, bus.busy);
        end
        cyc = 0;
        n = 0;
        while (cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.instr_valid) begin
                if (n < 16)
                    got[n] = bus.instr;
                n++;
            end
            if (cyc == 3 || cyc == 4) begin
                tests++;
                if (bus.instr !== 4'b0110 || bus.instr_valid !== 1'b0 || bus.pc !== 4'd2) begin
                    fails++;
                    $display("FAIL stall_hold_c%0d: instr=%b valid=%b pc=%0d expected 0110 0 2",
                             cyc, bus.instr, bus.instr_valid, bus.pc);
                end
            end
            if (cyc == 5) begin
                tests++;
                if (bus.instr !== 4'b0100 || bus.instr_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL stall_resume: instr=%b valid=%b expected 0100 1",
                             bus.instr, bus.instr_valid);
                end
            end
            bus.stall = (cyc == 2 || cyc == 3);
            if (bus.done)
                break;
        end
        bus.stall = 1'b0;
        tests++;
        if (n !== 5 || cyc !== 9) begin
            fails++;
            $display("FAIL stall_count: issues=%0d done_cycle=%0d expected 5 9", n, cyc);
        end
        for (int i = 0; i < 5 && i < n; i++) begin
            tests++;
            if (got[i] !== prog[i]) begin
                fails++;
                $display("FAIL stall_word%0d: got %b expected %b", i, got[i], prog[i]);
            end
        end
        tests++;
        if (bus.result !== 4'b0101) begin
            fails++;
            $display("FAIL stall_result: got %b expected 0101", bus.result);
        end
    endtask

    task automatic test_halt0();
        load_word(4'd0, 4'b1111);
        bus.portout = 4'b1010;
        run_start(20, 1'b0);
        tests++;
        if (n_issued !== 0 || done_cyc !== 2) begin
            fails++;
            $display("FAIL halt0: issues=%0d done_cycle=%0d expected 0 2", n_issued, done_cyc);
        end
        tests++;
        if (bus.result !== 4'b1010 || bus.pc !== 4'd0) begin
            fails++;
            $display("FAIL halt0_result: result=%b pc=%0d expected 1010 0", bus.result, bus.pc);
        end
    endtask

    task automatic test_full();
        int bad;
        for (int i = 0; i < 16; i++)
            load_word(4'(i), 4'b0001);
        bus.portout = 4'b0110;
        run_start(40, 1'b0);
        bad = 0;
        for (int i = 0; i < 16 && i < n_issued; i++)
            if (issued[i] !== 4'b0001)
                bad++;
        tests++;
        if (n_issued !== 16 || bad !== 0 || first_cyc !== 1 || last_cyc !== 16) begin
            fails++;
            $display("FAIL full_issue: issues=%0d bad=%0d first=%0d last=%0d expected 16 0 1 16",
                     n_issued, bad, first_cyc, last_cyc);
        end
        tests++;
        if (done_cyc !== 17 || bus.pc !== 4'd15 || bus.done !== 1'b1) begin
            fails++;
            $display("FAIL full_end: done_cycle=%0d pc=%0d done=%b expected 17 15 1",
                     done_cyc, bus.pc, bus.done);
        end
        tests++;
        if (bus.result !== 4'b0110 || both_hi !== 0) begin
            fails++;
            $display("FAIL full_result: result=%b both_hi=%0d expected 0110 0", bus.result, both_hi);
        end
    endtask

    task automatic test_ignored_load();
        load_basic();
        bus.portout = 4'b0011;
        run_start(30, 1'b1);
        tests++;
        if (n_issued !== 5 || issued[1] !== 4'b0110 || done_cyc !== 7) begin
            fails++;
            $display("FAIL ignload_run: issues=%0d word1=%b done_cycle=%0d expected 5 0110 7",
                     n_issued, issued[1], done_cyc);
        end
        run_start(30, 1'b0);
        tests++;
        if (n_issued !== 5 || issued[1] !== 4'b0110) begin
            fails++;
            $display("FAIL ignload_restart: issues=%0d word1=%b expected 5 0110",
                     n_issued, issued[1]);
        end
        // A load on the same edge as start must be dropped.
        bus.load_en   = 1'b1;
        bus.load_addr = 4'd2;
        bus.load_data = 4'b1111;
        run_start(30, 1'b0);
        tests++;
        if (n_issued !== 5 || issued[2] !== 4'b0100) begin
            fails++;
            $display("FAIL ignload_start_prio: issues=%0d word2=%b expected 5 0100",
                     n_issued, issued[2]);
        end
    endtask

    task automatic test_midrun_reset();
        int cyc;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        while (cyc < 3) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        tests++;
        if (bus.instr !== 4'b0100 || bus.instr_valid !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre: instr=%b valid=%b expected 0100 1", bus.instr, bus.instr_valid);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.instr, bus.instr_valid, bus.pc, bus.busy, bus.done, bus.result}
            !== {4'b0000, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0}) begin
            fails++;
            $display("FAIL midrst_outputs: instr=%b valid=%b pc=%0d busy=%b done=%b result=%b",
                     bus.instr, bus.instr_valid, bus.pc, bus.busy, bus.done, bus.result);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.portout = 4'b1100;
        run_start(30, 1'b0);
        tests++;
        if (n_issued !== 5 || issued[0] !== 4'b1001 || issued[4] !== 4'b0111 || done_cyc !== 7) begin
            fails++;
            $display("FAIL midrst_replay: issues=%0d w0=%b w4=%b done_cycle=%0d expected 5 1001 0111 7",
                     n_issued, issued[0], issued[4], done_cyc);
        end
        tests++;
        if (bus.result !== 4'b1100) begin
            fails++;
            $display("FAIL midrst_result: got %b expected 1100", bus.result);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        prog[0] = 4'b1001;
        prog[1] = 4'b0110;
        prog[2] = 4'b0100;
        prog[3] = 4'b0101;
        prog[4] = 4'b0111;
        prog[5] = 4'b1111;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.start     = 1'b0;
        bus.stall     = 1'b0;
        bus.portout   = '0;
        test_reset();
        test_basic();
        test_stall();
        test_halt0();
        test_full();
        test_ignored_load();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
